// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, byte type and baud-rate helper
//   UART_DATA_W  data bits per UART character
//   uart_byte_t  one received/transmitted character
//   bit_cycles   system clocks per bit time for a given clock and baud rate
package uart_pkg;
   localparam int UART_DATA_W = 8;
   typedef logic [UART_DATA_W-1:0] uart_byte_t;
   function automatic int bit_cycles(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction
endpackage

// File: rtl/uart_rx_buffer_if.sv
// uart_rx_buffer_if: host-side bus of the receive buffer
//   data/valid/ready  first-word fall-through byte stream, pop on valid & ready
//   count             entries held, 0..DEPTH
//   flush             synchronous FIFO clear
//   overflow          sticky dropped-byte flag, cleared by clear_overflow
//   line_idle         one-cycle end-of-packet marker after a silent gap
//   master = host logic, slave = buffer
interface uart_rx_buffer_if
   import uart_pkg::*;
#(
   parameter int DEPTH = 16
) ();
   uart_byte_t               data;
   logic                     valid;
   logic                     ready;
   logic [$clog2(DEPTH):0]   count;
   logic                     flush;
   logic                     overflow;
   logic                     clear_overflow;
   logic                     line_idle;
   modport master (
      input  data, valid, count, overflow, line_idle,
      output ready, flush, clear_overflow
   );
   modport slave (
      output data, valid, count, overflow, line_idle,
      input  ready, flush, clear_overflow
   );
endinterface

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: synchronous first-word fall-through FIFO, async active-low reset
//   clk, rst_n       clock, asynchronous active-low reset
//   push, wr_data    write request; ignored when full unless a pop frees the slot
//   pop, rd_data     read request (ignored when empty); rd_data is the head
//   flush            clears pointers and count, discards same-cycle push/pop
//   count/full/empty occupancy
module uart_byte_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [W-1:0]  wr_data,
   output logic [W-1:0]  rd_data,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;
   always_comb begin
      empty    = count_q == '0;
      full     = count_q == CW'(DEPTH);
      do_pop   = pop & ~empty & ~flush;
      // a full FIFO still accepts a byte when the head leaves in the same cycle
      do_push  = push & (~full | do_pop) & ~flush;
      wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(do_push);
      rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(do_pop);
      count_d  = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
   end
   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end
endmodule

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: byte FIFO behind uart_rx with overflow flag and line-idle marker
//   i_SysClock, i_ResetN  clock, asynchronous active-low reset
//   i_RxByte, i_RxDone    byte and done level from uart_rx; a 0->1 of done is a byte
//   host                  host bus (data/valid/ready, count, flush, overflow, line_idle)
module uart_rx_buffer
   import uart_pkg::*;
#(
   parameter int SYS_CLOCK     = 50000000,
   parameter int UART_BAUDRATE = 115200,
   parameter int DEPTH         = 16,
   parameter int IDLE_BITS     = 20
) (
   input  logic              i_SysClock,
   input  logic              i_ResetN,
   input  uart_byte_t        i_RxByte,
   input  logic              i_RxDone,
   uart_rx_buffer_if.slave   host
);
   localparam int BIT_CYCLES = bit_cycles(SYS_CLOCK, UART_BAUDRATE);
   localparam int IDLE_TICKS = IDLE_BITS * BIT_CYCLES;
   localparam int TW         = IDLE_TICKS > 1 ? $clog2(IDLE_TICKS) : 1;
   localparam logic [TW-1:0] TERM = TW'(IDLE_TICKS - 1);
   logic          done_q, done_d, ovf_q, ovf_d, armed_q, armed_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          rx_evt, pop, full, empty, idle_hit;
   uart_byte_fifo #(.W(UART_DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (i_SysClock),
      .rst_n   (i_ResetN),
      .push    (rx_evt),
      .pop     (pop),
      .flush   (host.flush),
      .wr_data (i_RxByte),
      .rd_data (host.data),
      .count   (host.count),
      .full    (full),
      .empty   (empty)
   );
   always_comb begin
      rx_evt   = i_RxDone & ~done_q;
      pop      = ~empty & host.ready;
      idle_hit = armed_q && tmr_q == TERM;
      done_d   = i_RxDone;
      // a new drop outranks a same-cycle clear; a flushed byte is not a drop
      ovf_d    = (rx_evt & full & ~pop & ~host.flush) | (ovf_q & ~host.clear_overflow);
      armed_d  = rx_evt | (armed_q & ~idle_hit);
      tmr_d    = rx_evt ? '0 : armed_q ? tmr_q + TW'(1) : tmr_q;
   end
   assign host.valid     = ~empty;
   assign host.overflow  = ovf_q;
   assign host.line_idle = idle_hit & ~rx_evt;
   always_ff @(posedge i_SysClock or negedge i_ResetN) begin
      if (!i_ResetN) begin
         // starts high so a done level already present at reset release is not a byte
         done_q  <= 1'b1;
         ovf_q   <= 1'b0;
         armed_q <= 1'b0;
         tmr_q   <= '0;
      end else begin
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         armed_q <= armed_d;
         tmr_q   <= tmr_d;
      end
   end
endmodule
